pipe_stage_skid_reg: RTL and testbench

Parametrised pipeline stage register for the ARM core. It replaces the fixed per-stage registers with one generic, width-configurable stage. The stage has a valid/ready handshake, a 2-entry skid buffer, upstream freeze, synchronous flush with control-bit bubbling, and a saturating stall counter. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and sustains full throughput under downstream back-pressure.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_stage_skid_reg_if.sv | 24 ++
 rtl/pipe_sat_counter.sv | 19 +
 rtl/pipe_stage_skid_reg.sv | 103 ++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline stage states, occupancy codes and per-stage control widths
package pipe_pkg;

   typedef enum logic [1:0] {
      PIPE_EMPTY = 2'd0,
      PIPE_FULL  = 2'd1,
      PIPE_SKID  = 2'd2
   } pipe_state_t;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_FULL  = 2'd1;
   localparam logic [1:0] OCC_SKID  = 2'd2;

   localparam int ID_CTRL_W  = 8;
   localparam int EX_CTRL_W  = 8;
   localparam int MEM_CTRL_W = 4;

endpackage

// File: rtl/pipe_stage_skid_reg_if.sv
// rtl/pipe_stage_skid_reg_if.sv - valid/ready handshake bundle between two pipeline stages
interface pipe_stage_skid_reg_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = pipe_pkg::ID_CTRL_W
);
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;

   modport master (
      output in_valid, in_ctrl, in_data, out_ready,
      input  in_ready, out_valid, out_ctrl, out_data
   );

   modport slave (
      input  in_valid, in_ctrl, in_data, out_ready,
      output in_ready, out_valid, out_ctrl, out_data
   );
endinterface

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter, cleared only by reset
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - generic pipeline stage register with 2-entry skid buffer,
// freeze, flush with control bubbling and saturating stall counter
module pipe_stage_skid_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 freeze,
   pipe_stage_skid_reg_if.slave bus,
   output logic [1:0]           occupancy,
   output logic [CNT_W-1:0]     stall_cnt
);

   pipe_state_t       state;
   logic [DATA_W-1:0] head_data;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] head_ctrl;
   logic [CTRL_W-1:0] skid_ctrl;
   logic              head_valid;
   logic              skid_valid;
   logic              in_fire;
   logic              out_fire;

   assign head_valid = (state != PIPE_EMPTY);
   assign skid_valid = (state == PIPE_SKID);

   // in_ready depends only on registered state, so no combinational path from out_ready
   assign bus.in_ready  = rst & ~skid_valid & ~freeze;
   assign in_fire       = bus.in_valid & bus.in_ready;
   assign out_fire      = head_valid & bus.out_ready;
   assign bus.out_valid = head_valid;
   assign bus.out_ctrl  = head_valid ? head_ctrl : '0;
   assign bus.out_data  = head_data;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= PIPE_EMPTY;
         occupancy <= OCC_EMPTY;
         head_data <= '0;
         head_ctrl <= '0;
         skid_data <= '0;
         skid_ctrl <= '0;
      end else if (flush) begin
         // payload is left in place; only the control bits are bubbled
         state     <= PIPE_EMPTY;
         occupancy <= OCC_EMPTY;
         head_ctrl <= '0;
         skid_ctrl <= '0;
      end else begin
         case (state)
            PIPE_EMPTY: begin
               if (in_fire) begin
                  state     <= PIPE_FULL;
                  occupancy <= OCC_FULL;
                  head_data <= bus.in_data;
                  head_ctrl <= bus.in_ctrl;
               end
            end
            PIPE_FULL: begin
               if (in_fire && out_fire) begin
                  head_data <= bus.in_data;
                  head_ctrl <= bus.in_ctrl;
               end else if (in_fire) begin
                  state     <= PIPE_SKID;
                  occupancy <= OCC_SKID;
                  skid_data <= bus.in_data;
                  skid_ctrl <= bus.in_ctrl;
               end else if (out_fire) begin
                  state     <= PIPE_EMPTY;
                  occupancy <= OCC_EMPTY;
               end
            end
            PIPE_SKID: begin
               if (out_fire) begin
                  state     <= PIPE_FULL;
                  occupancy <= OCC_FULL;
                  head_data <= skid_data;
                  head_ctrl <= skid_ctrl;
               end
            end
            default: begin
               state     <= PIPE_EMPTY;
               occupancy <= OCC_EMPTY;
            end
         endcase
      end
   end

   pipe_sat_counter #(
      .CNT_W(CNT_W)
   ) u_stall_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (bus.in_valid & ~bus.in_ready & rst),
      .count(stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - bench for pipe_stage_skid_reg against a queue-based reference model
module tb_pipe_stage_skid_reg;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        freeze;
   logic [1:0]  occupancy;
   logic [15:0] stall_cnt;
   logic [1:0]  occupancy3;
   logic [2:0]  stall_cnt3;

   pipe_stage_skid_reg_if #(.DATA_W(32), .CTRL_W(8)) bus ();
   pipe_stage_skid_reg_if #(.DATA_W(32), .CTRL_W(8)) bus3 ();

   assign bus3.in_valid  = bus.in_valid;
   assign bus3.in_ctrl   = bus.in_ctrl;
   assign bus3.in_data   = bus.in_data;
   assign bus3.out_ready = bus.out_ready;

   pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
      .bus(bus), .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(8), .CNT_W(3)) dut3 (
      .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
      .bus(bus3), .occupancy(occupancy3), .stall_cnt(stall_cnt3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [7:0]  c;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   logic [31:0] head_last;
   int          cnt;
   int          cnt3;
   int          checks;
   int          errors;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_ready();
      return rst && !freeze && (q.size() < 2);
   endfunction

   task automatic model_update();
      bit   rdy;
      bit   ifire;
      bit   ofire;
      ent_t e;
      rdy   = model_ready();
      ifire = bus.in_valid && rdy;
      ofire = (q.size() > 0) && bus.out_ready;
      if (rst && bus.in_valid && !rdy) begin
         if (cnt < 65535) cnt++;
         if (cnt3 < 7) cnt3++;
      end
      if (!rst) begin
         q.delete();
         cnt = 0;
         cnt3 = 0;
         head_last = '0;
      end else if (flush) begin
         q.delete();
      end else begin
         if (ofire) void'(q.pop_front());
         if (ifire) begin
            e.c = bus.in_ctrl;
            e.d = bus.in_data;
            q.push_back(e);
         end
      end
      if (q.size() > 0) head_last = q[0].d;
   endtask

   task automatic compare();
      logic [7:0] exp_ctrl;
      exp_ctrl = '0;
      if (q.size() > 0) exp_ctrl = q[0].c;
      check_eq("out_valid", bus.out_valid, q.size() != 0);
      check_eq("out_ctrl", bus.out_ctrl, exp_ctrl);
      check_eq("out_data", bus.out_data, head_last);
      check_eq("in_ready", bus.in_ready, model_ready());
      check_eq("occupancy", occupancy, q.size());
      check_eq("stall_cnt", stall_cnt, cnt);
      check_eq("stall_cnt3", stall_cnt3, cnt3);
   endtask

   task automatic cycle(input logic iv, input logic [7:0] ic, input logic [31:0] id,
                        input logic ordy, input logic fl, input logic fz, input logic rs);
      bus.in_valid  = iv;
      bus.in_ctrl   = ic;
      bus.in_data   = id;
      bus.out_ready = ordy;
      flush         = fl;
      freeze        = fz;
      rst           = rs;
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cnt = 0;
      cnt3 = 0;
      head_last = '0;

      // reset
      cycle(1'b1, 8'h55, 32'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("reset_in_ready", bus.in_ready, 1'b0);
      check_eq("reset_out_data", bus.out_data, 32'h0);
      cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("post_reset_in_ready", bus.in_ready, 1'b1);

      // streaming at full throughput
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 8'h01, 32'h10 + i, 1'b1, 1'b0, 1'b0, 1'b1);
         check_eq("stream_data", bus.out_data, 32'h10 + i);
         check_eq("stream_occ", occupancy, 2'd1);
      end
      cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("stream_stall", stall_cnt, 16'd0);

      // back-pressure into the skid entry
      cycle(1'b1, 8'h02, 32'hA, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 8'h03, 32'hB, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("bp_occ", occupancy, 2'd2);
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'h04, 32'hE, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("bp_stall", stall_cnt, 16'd3);
      cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("bp_second", bus.out_data, 32'hB);
      check_eq("bp_ready_back", bus.in_ready, 1'b1);
      cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

      // flush while holding two entries
      cycle(1'b1, 8'hFF, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 8'hFF, 32'h2, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 8'h07, 32'hC, 1'b0, 1'b1, 1'b0, 1'b1);
      check_eq("flush_valid", bus.out_valid, 1'b0);
      check_eq("flush_ctrl", bus.out_ctrl, 8'h0);
      cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("flush_no_c", bus.out_valid, 1'b0);

      // freeze drains the output but accepts nothing
      cycle(1'b1, 8'h05, 32'hD, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 8'h06, 32'h30 + i, 1'b1, 1'b0, 1'b1, 1'b1);
         check_eq("freeze_ready", bus.in_ready, 1'b0);
      end
      cycle(1'b1, 8'h08, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("unfreeze_accept", bus.out_data, 32'h20);

      // reset mid-operation
      cycle(1'b1, 8'h09, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 8'h0A, 32'h41, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 8'h0B, 32'h42, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("midrst_occ", occupancy, 2'd0);
      check_eq("midrst_data", bus.out_data, 32'h0);
      cycle(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("midrst_ready", bus.in_ready, 1'b1);

      // saturation of the 3-bit counter
      cycle(1'b1, 8'h0C, 32'h50, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 8'h0D, 32'h51, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'h0E, 32'h52, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("sat_cnt3", stall_cnt3, 3'd7);
      check_eq("sat_cnt16", stall_cnt, 16'd10);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom,
               $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
               $urandom_range(0, 6) == 0, $urandom_range(0, 49) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
